// File: rtl/full_adder_pkg.sv
// Shared types for the registered 8-bit adder.
// Optional signed-overflow output is enabled by FULL_ADDER_8BIT_OVF_EN.
package full_adder_pkg;
    localparam int ADD_WIDTH = 8;
    typedef logic [ADD_WIDTH-1:0] add_word_t;
endpackage

// File: rtl/full_adder_bit.sv
// One-bit combinational full adder: the ripple cell of full_adder_8bit.
module full_adder_bit (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);
endmodule

// File: rtl/full_adder_8bit.sv
// Registered ripple-carry adder: {Cout, Sum} = A + B + Cin, one cycle latency.
// Define FULL_ADDER_8BIT_OVF_EN to add the registered signed-overflow output Ovf.
module full_adder_8bit
    import full_adder_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      valid_i,
    input  add_word_t A,
    input  add_word_t B,
    input  logic      Cin,
    output logic      valid_o,
    output add_word_t Sum,
    output logic      Cout
`ifdef FULL_ADDER_8BIT_OVF_EN
    ,
    output logic      Ovf
`endif
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] s;

    assign c[0] = Cin;

    // Carry ripples LSB to MSB through one cell per bit; this chain is the critical path.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        full_adder_bit u_bit (
            .a   (A[i]),
            .b   (B[i]),
            .cin (c[i]),
            .s   (s[i]),
            .cout(c[i+1])
        );
    end

    // Result registers only load on valid_i, so junk operands on idle cycles never reach them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_o <= 1'b0;
            Sum     <= '0;
            Cout    <= 1'b0;
`ifdef FULL_ADDER_8BIT_OVF_EN
            Ovf     <= 1'b0;
`endif
        end else begin
            valid_o <= valid_i;
            if (valid_i) begin
                Sum  <= s;
                Cout <= c[WIDTH];
`ifdef FULL_ADDER_8BIT_OVF_EN
                Ovf  <= c[WIDTH-1] ^ c[WIDTH];
`endif
            end
        end
    end
endmodule

// File: tb/tb_full_adder_8bit.sv
// Self-checking bench for full_adder_8bit: directed vector table, reset/hold
// sequences, and randomized traffic against an arithmetic reference model.
module tb_full_adder_8bit;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid_i;
    logic [7:0] A, B;
    logic       Cin;
    logic       valid_o;
    logic [7:0] Sum;
    logic       Cout;
`ifdef FULL_ADDER_8BIT_OVF_EN
    logic       Ovf;
`endif

    int checks = 0;
    int failures = 0;

    full_adder_8bit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .valid_i(valid_i),
        .A      (A),
        .B      (B),
        .Cin    (Cin),
        .valid_o(valid_o),
        .Sum    (Sum),
        .Cout   (Cout)
`ifdef FULL_ADDER_8BIT_OVF_EN
        ,
        .Ovf    (Ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_outputs(input string name, input logic v, input logic [7:0] s,
                                 input logic co, input logic ov);
        check({name, ".valid_o"}, 32'(valid_o), 32'(v));
        check({name, ".Sum"},     32'(Sum),     32'(s));
        check({name, ".Cout"},    32'(Cout),    32'(co));
`ifdef FULL_ADDER_8BIT_OVF_EN
        check({name, ".Ovf"},     32'(Ovf),     32'(ov));
`else
        if (ov === 1'bz) check({name, ".ovf_unused"}, 32'(ov), 32'(1'bz));
`endif
    endtask

    // Reference: plain integer arithmetic, unsigned for Sum/Cout, signed range test for Ovf.
    function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic cin);
        int u;
        int sg;
        logic [9:0] r;
        u  = int'(a) + int'(b) + int'(cin);
        sg = int'($signed(a)) + int'($signed(b)) + int'(cin);
        r[7:0] = 8'(u % 256);
        r[8]   = (u >= 256);
        r[9]   = (sg > 127) || (sg < -128);
        return r;
    endfunction

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        valid_i = v;
        A = a;
        B = b;
        Cin = c;
    endtask

    vec_t       vecs[7];
    logic [7:0] exp_sum;
    logic       exp_cout, exp_ovf, exp_vld;
    logic [9:0] m;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'hDB, 8'hAA, 1'b1, 8'h86, 1'b1, 1'b0};
        vecs[1] = '{8'h63, 8'h95, 1'b0, 8'hF8, 1'b0, 1'b0};
        vecs[2] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[3] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[4] = '{8'hDB, 8'hAA, 1'b1, 8'h86, 1'b1, 1'b0};
        vecs[5] = '{8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 1'b0};
        vecs[6] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};

        rst_n = 1'b0;
        valid_i = 1'b0;
        A = 8'h00;
        B = 8'h00;
        Cin = 1'b0;
        #1;
        check_outputs("reset", 1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed vectors issued back-to-back, one per cycle.
        for (int i = 0; i < 7; i++) begin
            drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), 1'b1, vecs[i].sum, vecs[i].cout, vecs[i].ovf);
        end

        // Idle cycles with garbage operands: result held, valid_o low.
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 8'($urandom), 8'($urandom), 1'($urandom));
            @(posedge clk);
            #1;
            check_outputs($sformatf("hold%0d", i), 1'b0, vecs[6].sum, vecs[6].cout, vecs[6].ovf);
        end

        // Mid-stream asynchronous reset: clears without a clock edge, and the
        // edge seen while reset is held must not capture anything.
        drive(1'b1, 8'hFF, 8'h01, 1'b1);
        @(posedge clk);
        #1;
        check_outputs("pre_rst", 1'b1, 8'h01, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_outputs("async_rst", 1'b0, 8'h00, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check_outputs("rst_edge", 1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        valid_i = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("post_rst_idle", 1'b0, 8'h00, 1'b0, 1'b0);

        // Randomized traffic against the arithmetic model.
        exp_sum = 8'h00;
        exp_cout = 1'b0;
        exp_ovf = 1'b0;
        exp_vld = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom), 1'($urandom));
            if (valid_i) begin
                m = model(A, B, Cin);
                exp_sum = m[7:0];
                exp_cout = m[8];
                exp_ovf = m[9];
            end
            exp_vld = valid_i;
            @(posedge clk);
            #1;
            check_outputs($sformatf("rnd%0d", i), exp_vld, exp_sum, exp_cout, exp_ovf);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
